// File: rtl/microwave_timer_ctrl_pkg.sv
// rtl/microwave_timer_ctrl_pkg.sv - shared state encodings and BCD constants for the cook timer
package microwave_timer_ctrl_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// rtl/microwave_timer_ctrl_if.sv - keypad/door inputs and display/magnetron outputs of the cook timer
interface microwave_timer_ctrl_if;
    import microwave_timer_ctrl_pkg::*;

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               start;
    logic               stop;
    logic               door_closed;
    logic [DIGIT_W-1:0] mins;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic               mag_on;
    logic               beep;
    logic [1:0]         state;

    // Front panel side: drives keys/door, watches the display
    modport master (
        output key_valid, key_digit, start, stop, door_closed,
        input  mins, sec_tens, sec_ones, mag_on, beep, state
    );

    // Controller side
    modport slave (
        input  key_valid, key_digit, start, stop, door_closed,
        output mins, sec_tens, sec_ones, mag_on, beep, state
    );

endinterface

// File: rtl/microwave_timer_ctrl_bcd_down_digit.sv
// rtl/microwave_timer_ctrl_bcd_down_digit.sv - one loadable BCD down-counting digit that wraps 0 -> MAX
module bcd_down_digit
    import microwave_timer_ctrl_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [DIGIT_W-1:0] i_shift_in,
    input  logic               i_shift_en,
    input  logic               i_clr,
    input  logic               i_dec_en,
    output logic [DIGIT_W-1:0] o_q,
    output logic               o_is_zero
);

    logic [DIGIT_W-1:0] r_q;

    // Clear wins over a keypad shift, which wins over a countdown step
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= i_shift_in;
        end else if (i_dec_en) begin
            r_q <= (r_q == '0) ? MAX : r_q - 4'd1;
        end
    end

    assign o_q       = r_q;
    assign o_is_zero = (r_q == '0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// rtl/microwave_timer_ctrl.sv - cook timer FSM, 1 Hz divider, beeper timing and BCD digit chain
module microwave_timer_ctrl
    import microwave_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int DONE_SECS = 3
) (
    input  logic                   clk,
    input  logic                   clrn,
    microwave_timer_ctrl_if.slave  io_bus
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(DONE_SECS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(DONE_SECS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mag_on;
    logic               r_beep;
    logic               w_mag_nxt;
    logic               w_beep_nxt;
    logic [DW-1:0]      r_div;
    logic [BW-1:0]      r_beep_cnt;

    logic [DIGIT_W-1:0] w_ones, w_tens, w_mins;
    logic               w_ones_zero, w_tens_zero, w_mins_zero;
    logic               w_div_last;
    logic               w_tick_dec;
    logic               w_ones_borrow, w_tens_borrow;
    logic               w_time_zero, w_time_one;
    logic               w_shift_en, w_clr;

    assign w_div_last  = (r_div == DIV_LAST);
    assign w_time_zero = w_mins_zero & w_tens_zero & w_ones_zero;
    assign w_time_one  = w_mins_zero & w_tens_zero & (w_ones == 4'd1);

    // A countdown step only happens while cooking undisturbed; stop/door-open discard the tick
    assign w_tick_dec    = (r_state == ST_COOK) & ~io_bus.stop & io_bus.door_closed & w_div_last;
    assign w_ones_borrow = w_tick_dec & w_ones_zero;
    assign w_tens_borrow = w_ones_borrow & w_tens_zero;

    // New sec_tens is the current sec_ones, so it must not exceed 5
    assign w_shift_en = (r_state == ST_IDLE) & ~io_bus.stop & io_bus.key_valid &
                        (io_bus.key_digit <= BCD_MAX_ONES) & (w_ones <= BCD_MAX_TENS);
    assign w_clr      = io_bus.stop & ((r_state == ST_IDLE) | (r_state == ST_PAUSE));

    bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
        .clk        (clk),
        .clrn       (clrn),
        .i_shift_in (io_bus.key_digit),
        .i_shift_en (w_shift_en),
        .i_clr      (w_clr),
        .i_dec_en   (w_tick_dec),
        .o_q        (w_ones),
        .o_is_zero  (w_ones_zero)
    );

    bcd_down_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
        .clk        (clk),
        .clrn       (clrn),
        .i_shift_in (w_ones),
        .i_shift_en (w_shift_en),
        .i_clr      (w_clr),
        .i_dec_en   (w_ones_borrow),
        .o_q        (w_tens),
        .o_is_zero  (w_tens_zero)
    );

    bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_mins (
        .clk        (clk),
        .clrn       (clrn),
        .i_shift_in (w_tens),
        .i_shift_en (w_shift_en),
        .i_clr      (w_clr),
        .i_dec_en   (w_tens_borrow),
        .o_q        (w_mins),
        .o_is_zero  (w_mins_zero)
    );

    // State register plus the registered magnetron/beeper outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= ST_IDLE;
            r_mag_on <= 1'b0;
            r_beep   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mag_on <= w_mag_nxt;
            r_beep   <= w_beep_nxt;
        end
    end

    // Next-state decision; stop always has top priority
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!io_bus.stop && io_bus.start && io_bus.door_closed && !w_time_zero)
                    w_state_nxt = ST_COOK;
            end
            ST_COOK: begin
                if (io_bus.stop || !io_bus.door_closed)
                    w_state_nxt = ST_PAUSE;
                else if (w_div_last && w_time_one)
                    w_state_nxt = ST_DONE;
            end
            ST_PAUSE: begin
                if (io_bus.stop)
                    w_state_nxt = ST_IDLE;
                else if (io_bus.start && io_bus.door_closed)
                    w_state_nxt = ST_COOK;
            end
            ST_DONE: begin
                if (io_bus.stop || (w_div_last && r_beep_cnt == BEEP_LAST))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs follow the state being entered so they move on the same edge
    always_comb begin
        w_mag_nxt  = (w_state_nxt == ST_COOK);
        w_beep_nxt = (w_state_nxt == ST_DONE);
    end

    // Tick divider: zero in IDLE, frozen in PAUSE and while COOK is being interrupted
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_div <= '0;
        end else begin
            case (r_state)
                ST_COOK: begin
                    if (!io_bus.stop && io_bus.door_closed)
                        r_div <= w_div_last ? '0 : r_div + 1'b1;
                end
                ST_DONE:  r_div <= w_div_last ? '0 : r_div + 1'b1;
                ST_PAUSE: r_div <= r_div;
                default:  r_div <= '0;
            endcase
        end
    end

    // Counts completed ticks spent beeping
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_beep_cnt <= '0;
        end else if (r_state != ST_DONE) begin
            r_beep_cnt <= '0;
        end else if (w_div_last) begin
            r_beep_cnt <= r_beep_cnt + 1'b1;
        end
    end

    assign io_bus.mins     = w_mins;
    assign io_bus.sec_tens = w_tens;
    assign io_bus.sec_ones = w_ones;
    assign io_bus.mag_on   = r_mag_on;
    assign io_bus.beep     = r_beep;
    assign io_bus.state    = r_state;

endmodule
